// File: rtl/pow_pkg.sv
// Shared types and helpers for the square-and-multiply power engine.
// State encoding, product width rule and an exponent bit-length helper.
package pow_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    // A full product of two R_W-bit operands needs twice the width.
    function automatic int prod_w(input int r_w);
        return 2 * r_w;
    endfunction

    localparam int DEF_R_W  = 16;
    localparam int PROD_W   = prod_w(DEF_R_W);

    // Number of bits up to and including the most significant set bit.
    function automatic int bit_len(input logic [31:0] v);
        int l;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) l = i + 1;
        end
        return l;
    endfunction

endpackage

// File: rtl/pow_mul.sv
// Truncating R_W x R_W multiplier with a flag for lost upper bits.
// Purely combinational; used for both acc*base and base*base.
module pow_mul
    import pow_pkg::*;
#(
    parameter int R_W = 16
) (
    input  logic [R_W-1:0] x,
    input  logic [R_W-1:0] y,
    output logic [R_W-1:0] prod,
    output logic           ovf
);

    localparam int PW = prod_w(R_W);

    logic [PW-1:0] full;

    // Full-width product, then split into kept and discarded halves.
    always_comb begin
        full = {{R_W{1'b0}}, x} * {{R_W{1'b0}}, y};
        prod = full[R_W-1:0];
        ovf  = |full[PW-1:R_W];
    end

endmodule

// File: rtl/pow_engine.sv
// Square-and-multiply a^n engine, one exponent bit per cycle.
// Result and overflow are held until the next completion.
module pow_engine
    import pow_pkg::*;
#(
    parameter int A_W = 8,
    parameter int N_W = 8,
    parameter int R_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go_i,
    input  logic [A_W-1:0] a_i,
    input  logic [N_W-1:0] n_i,
    output logic [R_W-1:0] output_reg,
    output logic           ovf_o,
    output logic           busy_o,
    output logic           sig_done
);

    state_t         state;
    state_t         state_nx;
    logic [R_W-1:0] base;
    logic [R_W-1:0] acc;
    logic [N_W-1:0] n;
    logic           acc_ovf;
    logic           base_ovf;
    logic [R_W-1:0] ab_prod;
    logic           ab_ovf;
    logic [R_W-1:0] bb_prod;
    logic           bb_ovf;
    logic           acc_zero;
    logic           finish;

    pow_mul #(.R_W(R_W)) u_mul_ab (
        .x    (acc),
        .y    (base),
        .prod (ab_prod),
        .ovf  (ab_ovf)
    );

    pow_mul #(.R_W(R_W)) u_mul_bb (
        .x    (base),
        .y    (base),
        .prod (bb_prod),
        .ovf  (bb_ovf)
    );

    // A truly zero accumulator makes the product exactly zero.
    assign acc_zero = (acc == '0) && !acc_ovf;
    assign finish   = (state == STEP) && (n == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go_i) state_nx = STEP;
            STEP:    if (n == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand load and per-bit square-and-multiply update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base     <= '0;
            acc      <= '0;
            n        <= '0;
            acc_ovf  <= 1'b0;
            base_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_i) begin
                        base     <= R_W'(a_i);
                        n        <= n_i;
                        acc      <= R_W'(1);
                        acc_ovf  <= 1'b0;
                        base_ovf <= 1'b0;
                    end
                end
                STEP: begin
                    if (n != '0) begin
                        if (n[0]) begin
                            acc <= ab_prod;
                            if (ab_ovf || (base_ovf && !acc_zero))
                                acc_ovf <= 1'b1;
                        end
                        if (n > N_W'(1)) begin
                            base <= bb_prod;
                            if (bb_ovf) base_ovf <= 1'b1;
                        end
                        n <= n >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status and held result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            output_reg <= '0;
            ovf_o      <= 1'b0;
            busy_o     <= 1'b0;
            sig_done   <= 1'b0;
        end else begin
            busy_o   <= (state_nx != IDLE);
            sig_done <= (state_nx == DONE);
            if (finish) begin
                output_reg <= acc;
                ovf_o      <= acc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pow_engine.sv
// Scoreboard bench for pow_engine: default widths plus a small-width sweep.
// Expected results come from a repeated-multiply reference model.
module tb_pow_engine;
    import pow_pkg::*;

    typedef struct {
        longint res;
        bit     ovf;
        int     due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    logic        rst0;
    logic        go0;
    logic [7:0]  a0;
    logic [7:0]  n0;
    logic [15:0] r0;
    logic        ovf0;
    logic        busy0;
    logic        done0;

    logic        rst1;
    logic        go1;
    logic [3:0]  a1;
    logic [3:0]  n1;
    logic [7:0]  r1;
    logic        ovf1;
    logic        busy1;
    logic        done1;

    pow_engine u_dut0 (
        .clk        (clk),
        .rst        (rst0),
        .go_i       (go0),
        .a_i        (a0),
        .n_i        (n0),
        .output_reg (r0),
        .ovf_o      (ovf0),
        .busy_o     (busy0),
        .sig_done   (done0)
    );

    pow_engine #(.A_W(4), .N_W(4), .R_W(8)) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
        .go_i       (go1),
        .a_i        (a1),
        .n_i        (n1),
        .output_reg (r1),
        .ovf_o      (ovf1),
        .busy_o     (busy1),
        .sig_done   (done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: multiply n times, truncating and latching overflow.
    function automatic void ref_pow(input int a, input int n, input int rw,
                                    output longint res, output bit ovf);
        longint mask;
        mask = (64'd1 << rw) - 1;
        res  = 1;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            res = res * a;
            if (res > mask) begin
                ovf = 1'b1;
                res = res & mask;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at cyc=%0d",
                     name, act, want, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s at cyc=%0d", name, cyc);
    endtask

    // Monitor for the default-width instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst0 && done0) begin
            if (q0.size() == 0) flag("d0_spurious_done");
            else begin
                e = q0.pop_front();
                check("d0_res", 64'(r0), 64'(e.res));
                check("d0_ovf", 64'(ovf0), 64'(e.ovf));
                check("d0_lat", 64'(cyc), 64'(e.due));
            end
        end else if (q0.size() > 0 && cyc > q0[0].due) begin
            flag("d0_timeout");
            void'(q0.pop_front());
        end
    end

    // Monitor for the narrow sweep instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst1 && done1) begin
            if (q1.size() == 0) flag("d1_spurious_done");
            else begin
                e = q1.pop_front();
                check("d1_res", 64'(r1), 64'(e.res));
                check("d1_ovf", 64'(ovf1), 64'(e.ovf));
                check("d1_lat", 64'(cyc), 64'(e.due));
            end
        end else if (q1.size() > 0 && cyc > q1[0].due) begin
            flag("d1_timeout");
            void'(q1.pop_front());
        end
    end

    task automatic issue0(input int a, input int n);
        int     k;
        longint r;
        bit     o;
        k = 0;
        @(negedge clk);
        while ((busy0 || done0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) flag("issue0_wait");
        ref_pow(a, n, 16, r, o);
        q0.push_back('{r, o, cyc + bit_len(n) + 2});
        a0  = 8'(a);
        n0  = 8'(n);
        go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
    endtask

    task automatic issue1(input int a, input int n);
        int     k;
        longint r;
        bit     o;
        k = 0;
        @(negedge clk);
        while ((busy1 || done1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) flag("issue1_wait");
        ref_pow(a, n, 8, r, o);
        q1.push_back('{r, o, cyc + bit_len(n) + 2});
        a1  = 4'(a);
        n1  = 4'(n);
        go1 = 1'b1;
        @(negedge clk);
        go1 = 1'b0;
    endtask

    task automatic idle0();
        int k;
        k = 0;
        while ((q0.size() > 0 || busy0 || done0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) flag("idle0_wait");
    endtask

    task automatic idle1();
        int k;
        k = 0;
        while ((q1.size() > 0 || busy1 || done1) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) flag("idle1_wait");
    endtask

    task automatic stream0();
        int c;
        int dir_a[8] = '{3, 2, 2, 255, 255, 0, 5, 0};
        int dir_n[8] = '{5, 15, 16, 2, 3, 0, 0, 200};

        // Timing of busy and done around one run of 3^5.
        issue0(3, 5);
        for (int i = 1; i <= 6; i++) begin
            check("busy_c", 64'(busy0), 64'(i <= 5));
            check("done_c", 64'(done0), 64'(i == 5));
            @(negedge clk);
        end
        idle0();

        for (int i = 0; i < 8; i++) issue0(dir_a[i], dir_n[i]);
        idle0();

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0)
                issue0(int'($urandom_range(0, 255)), int'($urandom_range(0, 20)));
            else
                issue0(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        idle0();

        // go held high: back-to-back runs, base changed during the first.
        @(negedge clk);
        c   = cyc;
        a0  = 8'd3;
        n0  = 8'd5;
        go0 = 1'b1;
        q0.push_back('{243, 1'b0, c + 5});
        q0.push_back('{16807, 1'b0, c + 11});
        repeat (2) @(negedge clk);
        a0 = 8'd7;
        repeat (6) @(negedge clk);
        go0 = 1'b0;
        idle0();

        // Reset in the middle of a long run.
        issue0(2, 255);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        q0.delete();
        @(negedge clk);
        check("rst_res", 64'(r0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        rst0 = 1'b1;
        repeat (12) @(negedge clk);
        issue0(3, 2);
        idle0();
    endtask

    task automatic sweep1();
        for (int a = 0; a < 16; a++) begin
            for (int n = 0; n < 16; n++) issue1(a, n);
        end
        idle1();
    endtask

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        go0  = 1'b0;
        go1  = 1'b0;
        a0   = '0;
        n0   = '0;
        a1   = '0;
        n1   = '0;
        repeat (3) @(negedge clk);
        check("init_res", 64'(r0), 64'd0);
        check("init_ovf", 64'(ovf0), 64'd0);
        check("init_busy", 64'(busy0), 64'd0);
        check("init_done", 64'(done0), 64'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        fork
            stream0();
            sweep1();
        join
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        flag("watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
